// File: rtl/w0rm_stage_fifo.sv
// First-word-fall-through valid/ready FIFO placed after the W0RM pipeline synchroniser register.
// Absorbs consumer backpressure so the producer keeps streaming while entries remain.
module w0rm_stage_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    localparam int unsigned CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  input_valid,
    output logic                  input_ready,
    input  logic [DATA_WIDTH-1:0] input_data,
    input  logic                  output_ready,
    output logic                  output_valid,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic [CNT_WIDTH-1:0]  count
);

    localparam int unsigned PTR_WIDTH = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic empty;
    logic full;
    logic push;
    logic pop;

    // Status and handshake; all interface outputs are forced quiet while reset is held.
    always_comb begin
        empty        = (cnt_q == '0);
        full         = (cnt_q == CNT_WIDTH'(DEPTH));
        input_ready  = !full && !reset;
        output_valid = !empty && !reset;
        output_data  = output_valid ? mem_q[rd_ptr_q] : '0;
        count        = reset ? '0 : cnt_q;
        push         = input_valid && input_ready;
        pop          = output_valid && output_ready;
    end

    // Next state: pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        if (push) begin
            mem_d[wr_ptr_q] = input_data;
            wr_ptr_d        = wr_ptr_q + PTR_WIDTH'(1);
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
        end

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_WIDTH'(1);
            2'b01:   cnt_d = cnt_q - CNT_WIDTH'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_w0rm_stage_fifo.sv
// Directed bench for w0rm_stage_fifo: reset, fill, drain, streaming wrap, simultaneous push/pop, mid-run reset.
module tb_w0rm_stage_fifo;

    logic        clk;
    logic        reset;
    logic        input_valid;
    logic        input_ready;
    logic [31:0] input_data;
    logic        output_ready;
    logic        output_valid;
    logic [31:0] output_data;
    logic [2:0]  count;

    int checks;
    int errors;

    w0rm_stage_fifo #(.DATA_WIDTH(32), .DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .input_data   (input_data),
        .output_ready (output_ready),
        .output_valid (output_valid),
        .output_data  (output_data),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; input_valid = 1'b1; input_data = 32'hDEAD_BEEF; output_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++; if (input_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", input_ready); end
            checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", output_valid); end
            checks++; if (output_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got %h want 0", output_data); end
            checks++; if (count !== 3'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
        end
        reset = 1'b0; input_valid = 1'b0;
        #1;
        checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b want 1", input_ready); end
        tick();
        checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL rel_out_valid got %b want 0", output_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL rel_count got %0d want 0", count); end
    endtask

    task automatic test_fill();
        logic [31:0] vals [4];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
        output_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            input_valid = 1'b1; input_data = vals[i];
            #1;
            checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got %b want 1", i, input_ready); end
            tick();
            checks++; if (count !== 3'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, count, i + 1); end
            checks++; if (output_data !== 32'h11) begin errors++; $display("FAIL fill_head[%0d] got %h want 11", i, output_data); end
        end
        checks++; if (input_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b want 0", input_ready); end
        input_data = 32'hAA;
        tick();
        input_valid = 1'b0;
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_reject_count got %0d want 4", count); end
        checks++; if (output_data !== 32'h11) begin errors++; $display("FAIL full_hold_head got %h want 11", output_data); end
    endtask

    task automatic test_drain();
        logic [31:0] vals [4];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;
        output_ready = 1'b1; input_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (output_data !== vals[i]) begin errors++; $display("FAIL drain_data[%0d] got %h want %h", i, output_data, vals[i]); end
            tick();
            checks++; if (count !== 3'(3 - i)) begin errors++; $display("FAIL drain_count[%0d] got %0d want %0d", i, count, 3 - i); end
            checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL drain_ready[%0d] got %b want 1", i, input_ready); end
        end
        checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL drain_empty_valid got %b want 0", output_valid); end
        checks++; if (output_data !== 32'h0) begin errors++; $display("FAIL drain_empty_data got %h want 0", output_data); end
    endtask

    task automatic test_stream_wrap();
        output_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            input_valid = 1'b1; input_data = 32'h100 + 32'(k);
            tick();
            checks++; if (output_data !== 32'h100 + 32'(k)) begin errors++; $display("FAIL stream_data[%0d] got %h want %h", k, output_data, 32'h100 + 32'(k)); end
            checks++; if (count !== 3'd1) begin errors++; $display("FAIL stream_count[%0d] got %0d want 1", k, count); end
        end
        input_valid = 1'b0;
        tick();
        checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL stream_end_valid got %b want 0", output_valid); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL stream_end_count got %0d want 0", count); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] order [4];
        order[0] = 32'h204; order[1] = 32'h205; order[2] = 32'h206; order[3] = 32'h207;
        output_ready = 1'b0; input_valid = 1'b1;
        input_data = 32'h201; tick();
        input_data = 32'h202; tick();
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_pre_count got %0d want 2", count); end
        output_ready = 1'b1;
        input_data = 32'h203; tick();
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count0 got %0d want 2", count); end
        checks++; if (output_data !== 32'h202) begin errors++; $display("FAIL b2b_head0 got %h want 202", output_data); end
        input_data = 32'h204; tick();
        checks++; if (count !== 3'd2) begin errors++; $display("FAIL b2b_count1 got %0d want 2", count); end
        checks++; if (output_data !== 32'h203) begin errors++; $display("FAIL b2b_head1 got %h want 203", output_data); end
        output_ready = 1'b0;
        input_data = 32'h205; tick();
        input_data = 32'h206; tick();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL b2b_full_count got %0d want 4", count); end
        output_ready = 1'b1; input_data = 32'h2AA;
        #1;
        checks++; if (input_ready !== 1'b0) begin errors++; $display("FAIL b2b_full_ready got %b want 0", input_ready); end
        tick();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL b2b_full_pop_count got %0d want 3", count); end
        checks++; if (output_data !== 32'h204) begin errors++; $display("FAIL b2b_full_pop_head got %h want 204", output_data); end
        output_ready = 1'b0; input_data = 32'h207;
        #1;
        checks++; if (input_ready !== 1'b1) begin errors++; $display("FAIL b2b_reopen_ready got %b want 1", input_ready); end
        tick();
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL b2b_refill_count got %0d want 4", count); end
        input_valid = 1'b0; output_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (output_data !== order[i]) begin errors++; $display("FAIL b2b_order[%0d] got %h want %h", i, output_data, order[i]); end
            tick();
        end
        checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL b2b_end_valid got %b want 0", output_valid); end
    endtask

    task automatic test_reset_mid();
        output_ready = 1'b0; input_valid = 1'b1;
        input_data = 32'h301; tick();
        input_data = 32'h302; tick();
        input_data = 32'h303; tick();
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL mid_pre_count got %0d want 3", count); end
        reset = 1'b1; input_data = 32'h3FF; output_ready = 1'b1;
        #1;
        checks++; if (input_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b want 0", input_ready); end
        tick();
        reset = 1'b0; input_valid = 1'b0; output_ready = 1'b0;
        #1;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL mid_count got %0d want 0", count); end
        checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b want 0", output_valid); end
        checks++; if (output_data !== 32'h0) begin errors++; $display("FAIL mid_data got %h want 0", output_data); end
        input_valid = 1'b1; input_data = 32'h55;
        tick();
        input_valid = 1'b0;
        checks++; if (output_valid !== 1'b1) begin errors++; $display("FAIL mid_push_valid got %b want 1", output_valid); end
        checks++; if (output_data !== 32'h55) begin errors++; $display("FAIL mid_push_data got %h want 55", output_data); end
        checks++; if (count !== 3'd1) begin errors++; $display("FAIL mid_push_count got %0d want 1", count); end
        output_ready = 1'b1;
        tick();
        checks++; if (output_valid !== 1'b0) begin errors++; $display("FAIL mid_final_valid got %b want 0", output_valid); end
        checks++; if (output_data !== 32'h0) begin errors++; $display("FAIL mid_final_data got %h want 0", output_data); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill();
        test_drain();
        test_stream_wrap();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
